// File: rtl/shadow_reg_writer.sv
// Commits a shadowed register: clear-read, then two identical writes, then a status response.
// Define SHADOW_REG_WRITER_READBACK_EN to add a verify read after the second write.
module shadow_reg_writer #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   // Request/response handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; a source holds valid and its payload stable until that edge.
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [AW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [1:0]    rsp_status_o,
   output logic          reg_valid_o,
   input  logic          reg_ready_i,
   output logic          reg_write_o,
   output logic [AW-1:0] reg_addr_o,
   output logic [DW-1:0] reg_wdata_o,
   input  logic [DW-1:0] reg_rdata_i,
   input  logic          reg_error_i,
   output logic [2:0]    dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR_RD = 3'd1,
      ST_WR0    = 3'd2,
      ST_WR1    = 3'd3,
`ifdef SHADOW_REG_WRITER_READBACK_EN
      ST_VFY_RD = 3'd4,
`endif
      ST_RESP   = 3'd5
   } state_e;

   localparam logic [1:0] STS_OK       = 2'b00;
   localparam logic [1:0] STS_BUS_ERR  = 2'b01;
   localparam logic [1:0] STS_MISMATCH = 2'b10;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    status_q, status_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         status_q <= STS_OK;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      status_d    = status_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      reg_valid_o = 1'b0;
      reg_write_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               addr_d   = req_addr_i;
               wdata_d  = req_wdata_i;
               status_d = STS_OK;
               state_d  = ST_CLR_RD;
            end
         end
         // The clear-read only resets the target's phase tracker; its data is discarded.
         ST_CLR_RD: begin
            reg_valid_o = 1'b1;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  status_d = STS_BUS_ERR;
                  state_d  = ST_RESP;
               end else begin
                  state_d = ST_WR0;
               end
            end
         end
         ST_WR0: begin
            reg_valid_o = 1'b1;
            reg_write_o = 1'b1;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  status_d = STS_BUS_ERR;
                  state_d  = ST_RESP;
               end else begin
                  state_d = ST_WR1;
               end
            end
         end
         ST_WR1: begin
            reg_valid_o = 1'b1;
            reg_write_o = 1'b1;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  status_d = STS_BUS_ERR;
                  state_d  = ST_RESP;
               end else begin
`ifdef SHADOW_REG_WRITER_READBACK_EN
                  state_d = ST_VFY_RD;
`else
                  state_d = ST_RESP;
`endif
               end
            end
         end
`ifdef SHADOW_REG_WRITER_READBACK_EN
         ST_VFY_RD: begin
            reg_valid_o = 1'b1;
            if (reg_ready_i) begin
               if (reg_error_i) begin
                  status_d = STS_BUS_ERR;
               end else if (reg_rdata_i != wdata_q) begin
                  status_d = STS_MISMATCH;
               end else begin
                  status_d = STS_OK;
               end
               state_d = ST_RESP;
            end
         end
`endif
         ST_RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifndef SHADOW_REG_WRITER_READBACK_EN
   // Read data only matters for the verify read, which this build does not have.
   logic unused_rdata;
   assign unused_rdata = ^reg_rdata_i;
`endif

   assign reg_addr_o   = addr_q;
   assign reg_wdata_o  = wdata_q;
   assign rsp_status_o = status_q;
   assign dbg_state_o  = state_q;

endmodule

// File: doc/shadow_reg_writer.md
SHADOW_REG_WRITER -- requirements
Module: shadow_reg_writer

Interface
REQ-001 SHALL have parameter AW, default 32: register address width.
REQ-002 SHALL have parameter DW, default 32: register data width.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1: upstream shadowed-write request valid.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted when high together with req_valid_i.
REQ-007 SHALL have port req_addr_i, input, AW: target shadowed register address.
REQ-008 SHALL have port req_wdata_i, input, DW: value to commit.
REQ-009 SHALL have port rsp_valid_o, output, 1: completion status valid.
REQ-010 SHALL have port rsp_ready_i, input, 1: upstream accepts status.
REQ-011 SHALL have port rsp_status_o, output, 2: 00 OK, 01 bus error, 10 readback mismatch, 11 unused.
REQ-012 SHALL have port reg_valid_o, output, 1: register-bus access valid.
REQ-013 SHALL have port reg_ready_i, input, 1: access completes in the cycle reg_valid_o && reg_ready_i.
REQ-014 SHALL have port reg_write_o, output, 1: 1 = write, 0 = read.
REQ-015 SHALL have port reg_addr_o, output, AW: access address.
REQ-016 SHALL have port reg_wdata_o, output, DW: write data.
REQ-017 SHALL have port reg_rdata_i, input, DW: read data, sampled on completion.
REQ-018 SHALL have port reg_error_i, input, 1: access error, sampled on completion.

Function
REQ-019 SHALL implement the FSM IDLE -> CLR_RD -> WR0 -> WR1 -> [VFY_RD] -> RESP -> IDLE.
REQ-020 SHALL assert req_ready_o only in IDLE; on handshake, latch addr/wdata and go to CLR_RD.
REQ-021 CLR_RD SHALL issue one read to the latched address, resetting the target's phase tracker; rdata is ignored.
REQ-022 WR0 and WR1 SHALL each issue one write of the identical latched wdata to the latched address.
REQ-023 SHALL hold reg_valid_o, reg_write_o, reg_addr_o and reg_wdata_o stable until completion; SHALL NOT deassert early.
REQ-024 SHALL leave each bus state the cycle after completion, with no idle bubble between bus states.
REQ-025 reg_error_i = 1 on any completion SHALL abort remaining accesses, set status 01 and enter RESP.
REQ-026 RESP SHALL hold rsp_valid_o = 1 and rsp_status_o stable until rsp_ready_i, then return to IDLE.
REQ-027 With a zero-wait bus and rsp_ready_i = 1, request-handshake to rsp_valid_o latency SHALL be 3 cycles without readback and 4 cycles with it.
REQ-028 req_valid_i outside IDLE SHALL be ignored; there SHALL be no queuing.
REQ-029 reg_ready_i without reg_valid_o SHALL be ignored.

Reset
REQ-030 While rst_ni = 0: state IDLE; req_ready_o = 1, rsp_valid_o = 0, rsp_status_o = 00, reg_valid_o = 0, reg_write_o = 0, reg_addr_o = 0, reg_wdata_o = 0.
REQ-031 Reset asserted mid-sequence SHALL drop reg_valid_o asynchronously and discard the request with no response.

Configuration
REQ-032 Macro SHADOW_REG_WRITER_READBACK_EN defined: after WR1, VFY_RD SHALL read the address; rdata != latched wdata gives status 10, reg_error_i gives 01, otherwise 00.
REQ-033 Macro undefined: VFY_RD SHALL NOT exist; WR1 completion SHALL go directly to RESP with status 00, or 01 on error.

Verification
REQ-034 Zero-wait bus, request addr 0x10 / data 0xA5A5_0F0F: bus shows read 0x10, write 0xA5A5_0F0F, write 0xA5A5_0F0F, then (macro on) read 0x10; status 00 with REQ-027 latency.
REQ-035 reg_ready_i delayed 3 cycles on each access: outputs stable throughout; ordering and status identical to REQ-034.
REQ-036 reg_error_i = 1 on WR0 completion: no WR1 issued; rsp_status_o = 01.
REQ-037 Macro on, readback returns 0xA5A5_0F0E: rsp_status_o = 10; macro off, same bench: status 00 with 3 bus accesses.
REQ-038 rsp_ready_i held low 5 cycles, new req_valid_i asserted meanwhile: response held stable; new request accepted only after returning to IDLE.
REQ-039 rst_ni pulsed during WR0 wait: reg_valid_o = 0 immediately; after release, IDLE with req_ready_o = 1 and no response emitted.
